// File: rtl/adxl357_frame_averager.sv
// ADXL357 frame averager: spots each completed 11-byte ACC read of the
// controller, captures one coherent X/Y/Z/TEMP frame, box-car averages
// 2^AVG_LOG2 frames and raises o_stale when frames stop arriving.
//
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_ctrl_state     controller state code (async to i_clk)
//   i_acc_x/y/z      signed 20-bit samples, sign-extended to 32
//   i_temp           unsigned 12-bit temperature, zero-extended to 32
//   i_clear          synchronous restart of accumulation
//   o_acc_x/y/z      averaged samples, sign-extended
//   o_temp           averaged temperature, zero-extended
//   o_valid          one-cycle strobe on output update
//   o_frame_cnt      accepted frame count (wraps)
//   o_stale          no frame seen within TIMEOUT_CYC cycles
module adxl357_frame_averager #(
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_ctrl_state,
  input  logic [31:0] i_acc_x,
  input  logic [31:0] i_acc_y,
  input  logic [31:0] i_acc_z,
  input  logic [31:0] i_temp,
  input  logic        i_clear,
  output logic [31:0] o_acc_x,
  output logic [31:0] o_acc_y,
  output logic [31:0] o_acc_z,
  output logic [31:0] o_temp,
  output logic        o_valid,
  output logic [15:0] o_frame_cnt,
  output logic        o_stale
);

  localparam int AW = 20 + AVG_LOG2;
  localparam int TW = 12 + AVG_LOG2;
  localparam logic [4:0]  N_FULL = 5'(1 << AVG_LOG2);
  localparam logic [22:0] TO_MAX = 23'(TIMEOUT_CYC);
  localparam logic [7:0]  ST_IDLE  = 8'd0;
  localparam logic [7:0]  ST_ACK11 = 8'd32;

  typedef enum logic {
    ARM_WAIT = 1'b0,
    ARMED    = 1'b1
  } fsm_t;

  logic [7:0] s1, s2, s3;
  logic       st_valid;
  fsm_t       state;
  logic       frame_evt;

  logic        cap_pend;
  logic [31:0] cap_x, cap_y, cap_z, cap_t;
  logic        in_range;
  logic        accept;

  logic signed [AW-1:0] acc_x, acc_y, acc_z;
  logic signed [AW-1:0] sum_x, sum_y, sum_z;
  logic [TW-1:0]        acc_t, sum_t;
  logic [4:0]           n, n_inc;
  logic [22:0]          tcnt;

  // Upper 13 bits all equal means the value fits a signed 20-bit range.
  function automatic logic fits20(input logic [12:0] hi);
    return (hi == 13'h0000) || (hi == 13'h1fff);
  endfunction

  // A code is trusted only once it has been seen on two successive
  // cycles, so a multi-bit skew through the synchroniser never decides.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= ST_IDLE;
      s2 <= ST_IDLE;
      s3 <= ST_IDLE;
    end else begin
      s1 <= i_ctrl_state;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign st_valid  = (s2 == s3);
  assign frame_evt = (state == ARMED) && st_valid && (s2 == ST_IDLE);

  // Only the ACC burst passes WRITE_ACK11, so arming on it and firing
  // on the return to IDLE ignores temperature and register writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ARM_WAIT;
    end else if (i_clear) begin
      state <= ARM_WAIT;
    end else begin
      unique case (state)
        ARM_WAIT:
          if (st_valid && s2 == ST_ACK11)
            state <= ARMED;
        ARMED:
          if (frame_evt)
            state <= ARM_WAIT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cap_pend <= 1'b0;
      cap_x    <= '0;
      cap_y    <= '0;
      cap_z    <= '0;
      cap_t    <= '0;
    end else begin
      cap_pend <= frame_evt && !i_clear;
      if (frame_evt) begin
        cap_x <= i_acc_x;
        cap_y <= i_acc_y;
        cap_z <= i_acc_z;
        cap_t <= i_temp;
      end
    end
  end

  assign in_range = fits20(cap_x[31:19]) &&
                    fits20(cap_y[31:19]) &&
                    fits20(cap_z[31:19]) &&
                    (cap_t[31:12] == 20'h0);

  assign accept = cap_pend && in_range && !i_clear;

  assign sum_x = acc_x + AW'($signed(cap_x[19:0]));
  assign sum_y = acc_y + AW'($signed(cap_y[19:0]));
  assign sum_z = acc_z + AW'($signed(cap_z[19:0]));
  assign sum_t = acc_t + TW'(cap_t[11:0]);
  assign n_inc = n + 5'd1;

  // Dropping the low AVG_LOG2 bits of the signed sum is the floor
  // division; the accumulators are wide enough that no bit is lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_x       <= '0;
      acc_y       <= '0;
      acc_z       <= '0;
      acc_t       <= '0;
      n           <= '0;
      o_acc_x     <= '0;
      o_acc_y     <= '0;
      o_acc_z     <= '0;
      o_temp      <= '0;
      o_valid     <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_valid <= 1'b0;
      if (i_clear) begin
        acc_x <= '0;
        acc_y <= '0;
        acc_z <= '0;
        acc_t <= '0;
        n     <= '0;
      end else if (accept) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
        if (n_inc == N_FULL) begin
          o_acc_x <= 32'($signed(sum_x[AW-1:AVG_LOG2]));
          o_acc_y <= 32'($signed(sum_y[AW-1:AVG_LOG2]));
          o_acc_z <= 32'($signed(sum_z[AW-1:AVG_LOG2]));
          o_temp  <= 32'(sum_t[TW-1:AVG_LOG2]);
          o_valid <= 1'b1;
          acc_x   <= '0;
          acc_y   <= '0;
          acc_z   <= '0;
          acc_t   <= '0;
          n       <= '0;
        end else begin
          acc_x <= sum_x;
          acc_y <= sum_y;
          acc_z <= sum_z;
          acc_t <= sum_t;
          n     <= n_inc;
        end
      end
    end
  end

  // Any detected frame, even a rejected one, proves the sensor is alive
  // and restarts the timer; only an accepted frame clears the flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tcnt    <= '0;
      o_stale <= 1'b0;
    end else begin
      if (frame_evt)
        tcnt <= '0;
      else if (tcnt != TO_MAX)
        tcnt <= tcnt + 23'd1;
      if (accept)
        o_stale <= 1'b0;
      else if (tcnt == TO_MAX)
        o_stale <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adxl357_frame_averager.sv
// Bench for adxl357_frame_averager: two instances (pass-through and
// 4-frame average) share stimulus and are scored against a model.
module tb_adxl357_frame_averager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  st = 8'd0;
  logic [31:0] ax = '0, ay = '0, az = '0, at = '0;
  logic        clr = 1'b0;

  logic [31:0] ox [2];
  logic [31:0] oy [2];
  logic [31:0] oz [2];
  logic [31:0] ot [2];
  logic        ov [2];
  logic [15:0] ofc [2];
  logic        ost [2];

  always #5 clk = ~clk;

  adxl357_frame_averager #(.AVG_LOG2(0), .TIMEOUT_CYC(1000)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ctrl_state(st),
    .i_acc_x(ax), .i_acc_y(ay), .i_acc_z(az), .i_temp(at),
    .i_clear(clr),
    .o_acc_x(ox[0]), .o_acc_y(oy[0]), .o_acc_z(oz[0]), .o_temp(ot[0]),
    .o_valid(ov[0]), .o_frame_cnt(ofc[0]), .o_stale(ost[0])
  );

  adxl357_frame_averager #(.AVG_LOG2(2), .TIMEOUT_CYC(1000)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ctrl_state(st),
    .i_acc_x(ax), .i_acc_y(ay), .i_acc_z(az), .i_temp(at),
    .i_clear(clr),
    .o_acc_x(ox[1]), .o_acc_y(oy[1]), .o_acc_z(oz[1]), .o_temp(ot[1]),
    .o_valid(ov[1]), .o_frame_cnt(ofc[1]), .o_stale(ost[1])
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int vcnt [2] = '{0, 0};
  int vcyc [2] = '{0, 0};

  always @(posedge clk) cyc++;

  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      if (ov[d]) begin
        vcnt[d]++;
        vcyc[d] = cyc;
      end

  // Reference model: index 0 averages 1 frame, index 1 averages 4.
  int          mn [2];
  longint      msx [2], msy [2], msz [2], mst [2];
  logic [31:0] mex [2], mey [2], mez [2], met [2];
  int          mv [2];
  logic [15:0] mf [2];

  function automatic int fdiv(input longint s, input int n);
    longint q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return int'(q);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mn[d] = 0;
      msx[d] = 0; msy[d] = 0; msz[d] = 0; mst[d] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear();
    for (int d = 0; d < 2; d++) begin
      mex[d] = '0; mey[d] = '0; mez[d] = '0; met[d] = '0;
      mv[d] = 0;
      mf[d] = '0;
      vcnt[d] = 0;
    end
  endtask

  task automatic model_frame(input logic [31:0] x, y, z, t);
    int xs, ys, zs, nf;
    bit ok;
    xs = $signed(x); ys = $signed(y); zs = $signed(z);
    ok = xs >= -524288 && xs <= 524287 &&
         ys >= -524288 && ys <= 524287 &&
         zs >= -524288 && zs <= 524287 && t < 32'd4096;
    if (!ok) return;
    for (int d = 0; d < 2; d++) begin
      nf = 1 << (2 * d);
      mf[d]++;
      mn[d]++;
      msx[d] += xs; msy[d] += ys; msz[d] += zs; mst[d] += t;
      if (mn[d] == nf) begin
        mex[d] = fdiv(msx[d], nf);
        mey[d] = fdiv(msy[d], nf);
        mez[d] = fdiv(msz[d], nf);
        met[d] = 32'(mst[d] / nf);
        mv[d]++;
        mn[d] = 0;
        msx[d] = 0; msy[d] = 0; msz[d] = 0; mst[d] = 0;
      end
    end
  endtask

  function automatic logic [31:0] r20();
    int v;
    v = int'($urandom_range(1048575)) - 524288;
    return 32'(v);
  endfunction

  function automatic logic [31:0] rbad();
    if ($urandom_range(1) == 1)
      return 32'h00080000 + 32'($urandom_range(1000));
    return 32'hFFF00000 - 32'($urandom_range(1000));
  endfunction

  // Drives one ACC read (31,32,33,34,0); c0 is the cycle the IDLE code
  // is applied. clr_at > 0 raises i_clear on that cycle after c0.
  task automatic send_frame(input logic [31:0] x, y, z, t,
                            input int clr_at, output int c0);
    int codes [4] = '{31, 32, 33, 34};
    ax = x; ay = y; az = z; at = t;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      st = 8'(codes[i]);
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    st = 8'd0;
    c0 = cyc;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      clr = (k == clr_at);
    end
    clr = 1'b0;
    if (clr_at > 0) model_clear();
    else model_frame(x, y, z, t);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ox[d], oy[d], oz[d], ot[d], ov[d], ofc[d], ost[d]} !== '0)
        $display("FAIL reset_state dut%0d got %h %h %b %0d %b exp 0",
                 d, ox[d], ot[d], ov[d], ofc[d], ost[d]);
      else passed++;
    end
  endtask

  task automatic test_passthrough();
    int c0;
    send_frame(32'hFFFFFFFF, 32'd5, 32'hFFF80000, 32'h7FF, 0, c0);
    checks++;
    if (vcyc[0] !== c0 + 5)
      $display("FAIL pass_latency got %0d exp %0d", vcyc[0], c0 + 5);
    else passed++;
    checks++;
    if (vcnt[0] !== 1)
      $display("FAIL pass_vcnt got %0d exp 1", vcnt[0]);
    else passed++;
    checks++;
    if ({ox[0], oy[0], oz[0], ot[0]} !==
        {32'hFFFFFFFF, 32'd5, 32'hFFF80000, 32'h7FF})
      $display("FAIL pass_data got %h %h %h %h", ox[0], oy[0], oz[0], ot[0]);
    else passed++;
    checks++;
    if (ofc[0] !== 16'd1 || ofc[1] !== 16'd1)
      $display("FAIL pass_fcnt got %0d %0d exp 1 1", ofc[0], ofc[1]);
    else passed++;
    checks++;
    if (vcnt[1] !== 0)
      $display("FAIL pass_avg_novalid got %0d exp 0", vcnt[1]);
    else passed++;
  endtask

  task automatic test_average();
    int xa [8] = '{10, 11, 12, -1, -1, -1, -1, -2};
    int c0;
    pulse_clear();
    for (int i = 0; i < 8; i++) begin
      send_frame(32'(xa[i]), r20(), r20(), 32'($urandom_range(4095)), 0, c0);
      checks++;
      if (vcnt[1] !== mv[1])
        $display("FAIL avg_vcnt f%0d got %0d exp %0d", i, vcnt[1], mv[1]);
      else passed++;
      checks++;
      if ({ox[1], oy[1], oz[1], ot[1]} !== {mex[1], mey[1], mez[1], met[1]})
        $display("FAIL avg_data f%0d got %h %h %h %h exp %h %h %h %h", i,
                 ox[1], oy[1], oz[1], ot[1], mex[1], mey[1], mez[1], met[1]);
      else passed++;
      checks++;
      if (ox[0] !== 32'(xa[i]))
        $display("FAIL avg_pass_x f%0d got %h exp %h", i, ox[0], 32'(xa[i]));
      else passed++;
      if (i == 3) begin
        checks++;
        if (ox[1] !== 32'd8)
          $display("FAIL avg_x_8 got %h exp 00000008", ox[1]);
        else passed++;
      end
      if (i == 7) begin
        checks++;
        if (ox[1] !== 32'hFFFFFFFE)
          $display("FAIL avg_x_m2 got %h exp fffffffe", ox[1]);
        else passed++;
      end
    end
  endtask

  task automatic test_temp_only();
    int codes [5] = '{13, 14, 33, 34, 0};
    ax = r20(); ay = r20(); az = r20(); at = 32'd100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      st = 8'(codes[i]);
      repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ofc[d] !== mf[d] || vcnt[d] !== mv[d])
        $display("FAIL temp_only dut%0d got %0d/%0d exp %0d/%0d",
                 d, ofc[d], vcnt[d], mf[d], mv[d]);
      else passed++;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      st = (i % 2 == 0) ? 8'd32 : 8'd0;
    end
    @(negedge clk);
    st = 8'd0;
    repeat (8) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ofc[d] !== mf[d] || vcnt[d] !== mv[d])
        $display("FAIL glitch dut%0d got %0d/%0d exp %0d/%0d",
                 d, ofc[d], vcnt[d], mf[d], mv[d]);
      else passed++;
    end
  endtask

  task automatic test_stale_range();
    int c0, rc;
    pulse_clear();
    send_frame(r20(), r20(), r20(), 32'd200, 0, c0);
    send_frame(r20(), r20(), r20(), 32'd300, 0, c0);
    rc = -1;
    for (int k = 0; k < 1200 && rc < 0; k++) begin
      @(negedge clk);
      if (ost[1]) rc = cyc;
    end
    checks++;
    if (rc !== c0 + 1005)
      $display("FAIL stale_rise got %0d exp %0d", rc, c0 + 1005);
    else passed++;
    checks++;
    if (ost[0] !== 1'b1)
      $display("FAIL stale_rise_pass got %b exp 1", ost[0]);
    else passed++;
    send_frame(r20(), r20(), r20(), 32'd400, 0, c0);
    checks++;
    if (ost[0] !== 1'b0 || ost[1] !== 1'b0)
      $display("FAIL stale_clear got %b %b exp 0 0", ost[0], ost[1]);
    else passed++;
    send_frame(r20(), r20(), r20(), 32'd500, 0, c0);
    checks++;
    if (vcnt[1] !== mv[1] ||
        {ox[1], oy[1], oz[1], ot[1]} !== {mex[1], mey[1], mez[1], met[1]})
      $display("FAIL stale_partial got %0d %h %h exp %0d %h %h",
               vcnt[1], ox[1], ot[1], mv[1], mex[1], met[1]);
    else passed++;
    repeat (600) @(negedge clk);
    send_frame(r20(), 32'h00080000, r20(), 32'd10, 0, c0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ofc[d] !== mf[d] || vcnt[d] !== mv[d])
        $display("FAIL range_reject dut%0d got %0d/%0d exp %0d/%0d",
                 d, ofc[d], vcnt[d], mf[d], mv[d]);
      else passed++;
    end
    rc = -1;
    for (int k = 0; k < 1200 && rc < 0; k++) begin
      @(negedge clk);
      if (ost[1]) rc = cyc;
    end
    checks++;
    if (rc !== c0 + 1005)
      $display("FAIL reject_timer got %0d exp %0d", rc, c0 + 1005);
    else passed++;
    send_frame(r20(), r20(), 32'h00100000, 32'd10, 0, c0);
    checks++;
    if (ost[1] !== 1'b1)
      $display("FAIL reject_keeps_stale got %b exp 1", ost[1]);
    else passed++;
    send_frame(r20(), r20(), r20(), 32'd10, 0, c0);
    checks++;
    if (ost[1] !== 1'b0)
      $display("FAIL stale_clear2 got %b exp 0", ost[1]);
    else passed++;
  endtask

  task automatic test_clear_mid();
    int c0;
    pulse_clear();
    send_frame(r20(), r20(), r20(), 32'd1, 0, c0);
    send_frame(r20(), r20(), r20(), 32'd2, 0, c0);
    send_frame(32'd99999, r20(), r20(), 32'd3, 3, c0);
    for (int i = 0; i < 4; i++) begin
      send_frame(r20(), r20(), r20(), 32'($urandom_range(4095)), 0, c0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (vcnt[d] !== mv[d] || ofc[d] !== mf[d] ||
            {ox[d], oy[d], oz[d], ot[d]} !==
            {mex[d], mey[d], mez[d], met[d]})
          $display("FAIL clear_mid f%0d dut%0d got %0d %0d %h exp %0d %0d %h",
                   i, d, vcnt[d], ofc[d], ox[d], mv[d], mf[d], mex[d]);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    int c0, k;
    logic [31:0] x, y, z, t;
    for (int i = 0; i < 24; i++) begin
      x = r20(); y = r20(); z = r20();
      t = 32'($urandom_range(4095));
      k = int'($urandom_range(19));
      if (k == 0) x = rbad();
      if (k == 1) y = rbad();
      if (k == 2) z = rbad();
      if (k == 3) t = 32'h1000 | 32'($urandom_range(4095));
      if (k == 4) x = 32'h0007FFFF;
      if (k == 5) y = 32'hFFF80000;
      send_frame(x, y, z, t, 0, c0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (vcnt[d] !== mv[d])
          $display("FAIL rnd_vcnt f%0d dut%0d got %0d exp %0d",
                   i, d, vcnt[d], mv[d]);
        else passed++;
        checks++;
        if ({ox[d], oy[d], oz[d], ot[d]} !== {mex[d], mey[d], mez[d], met[d]})
          $display("FAIL rnd_data f%0d dut%0d got %h %h %h %h exp %h %h %h %h",
                   i, d, ox[d], oy[d], oz[d], ot[d],
                   mex[d], mey[d], mez[d], met[d]);
        else passed++;
        checks++;
        if (ofc[d] !== mf[d])
          $display("FAIL rnd_fcnt f%0d dut%0d got %0d exp %0d",
                   i, d, ofc[d], mf[d]);
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    int c0;
    send_frame(r20(), r20(), r20(), 32'd7, 0, c0);
    send_frame(r20(), r20(), r20(), 32'd8, 0, c0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ox[d], oy[d], oz[d], ot[d], ov[d], ofc[d], ost[d]} !== '0)
        $display("FAIL async_reset dut%0d got %h %h %b %0d %b exp 0",
                 d, ox[d], ot[d], ov[d], ofc[d], ost[d]);
      else passed++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_frame(32'd1234, 32'hFFFFFF00, 32'd0, 32'd4095, 0, c0);
    checks++;
    if (vcnt[0] !== 1 || {ox[0], ot[0]} !== {32'd1234, 32'd4095})
      $display("FAIL post_reset got %0d %h %h exp 1 000004d2 00000fff",
               vcnt[0], ox[0], ot[0]);
    else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_passthrough();
    test_average();
    test_temp_only();
    test_stale_range();
    test_clear_mid();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
